// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: steps each instruction through fetch/decode/execute/memory/write-back
// and drives the datapath enables, mux selects and a retired-instruction counter.
module multicycle_control_unit #(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_2_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_e;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rdy;

   assign rdy = mem_ready | !MEM_HANDSHAKE;

   // NOTE: reset is sampled on the clock edge only; non-blocking assignments keep every flop
   // updating from pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_2_reg     = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      // Outputs stay at zero for the whole reset cycle so no write can slip out.
      if (arst_n) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = rdy;
               pc_write  = rdy;
               if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
               alu_src_b = 2'b11;
               case (opcode)
                  OP_LW, OP_SW: state_d = S_MEM_ADDR;
                  OP_R:         state_d = S_EXECUTE;
                  OP_BEQ:       state_d = S_BRANCH;
                  OP_J:         state_d = S_JUMP;
                  OP_ADDI:      state_d = S_ADDI_EXEC;
                  default: begin
                     illegal_op = 1'b1;
                     state_d    = S_FETCH;
                  end
               endcase
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               if (state_q == S_ADDI_EXEC) state_d = S_ADDI_WB;
               else if (opcode == OP_LW)   state_d = S_MEM_READ;
               else                        state_d = S_MEM_WRITE;
            end
            S_MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
               if (rdy) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_2_reg  = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
               mem_write  = 1'b1;
               i_or_d     = 1'b1;
               instr_done = rdy;
               if (rdy) state_d = S_FETCH;
            end
            S_EXECUTE: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
               state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_ADDI_WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               instr_done    = 1'b1;
               state_d       = S_FETCH;
            end
            S_JUMP: begin
               pc_write   = 1'b1;
               pc_source  = 2'b10;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q + CNT_W'(instr_done);
   end

   assign state       = arst_n ? state_q : S_FETCH;
   assign instr_count = arst_n ? cnt_q : '0;

endmodule
